// File: rtl/sqrt_pkg.sv
// Shared types and elaboration helpers for the iterative square-root unit.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Radicand width must be even (two bits consumed per root bit) and at least 4.
  function automatic bit width_ok(input int w);
    return ((w % 32'sd2) == 32'sd0) && (w >= 32'sd4);
  endfunction

  // Iteration counter width: enough to hold RW-1, never narrower than one bit.
  function automatic int cnt_width(input int rw);
    return (rw > 32'sd1) ? $clog2(rw) : 32'sd1;
  endfunction

endpackage

// File: rtl/sqrt_reg.sv
// Load-enabled register with synchronous active-high clear.
module sqrt_reg #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Clear on reset, otherwise load d when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= {N{1'b0}};
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration (purely combinational).
// The partial remainder never needs more than RW bits before the shift, so
// only r[RW-1:0] feeds the trial subtraction.
module sqrt_step #(
  parameter int RW = 4
) (
  input  logic [RW+1:0] r,
  input  logic [RW-1:0] q,
  input  logic [1:0]    pair,
  output logic [RW+1:0] r_next,
  output logic [RW-1:0] q_next
);

  logic [RW+1:0] rs_s;
  logic [RW+2:0] t_s;
  logic          unused_s;

  // Bits that are provably zero or shifted out; kept only to document that.
  assign unused_s = ^{r[RW+1:RW], q[RW-1]};

  // Shift in the next radicand pair and try subtracting {q,01}; keep on no borrow.
  always_comb begin
    rs_s = {r[RW-1:0], pair};
    t_s  = {1'b0, rs_s} - {1'b0, q, 2'b01};
    if (t_s[RW+2]) begin
      r_next = rs_s;
      q_next = {q[RW-2:0], 1'b0};
    end else begin
      r_next = t_s[RW+1:0];
      q_next = {q[RW-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/sqrt_iter.sv
// Iterative integer square root: one root bit per cycle, floor root plus
// remainder, one-cycle done pulse, back-to-back starts accepted in DONE.
module sqrt_iter
  import sqrt_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   din,
  output logic           busy,
  output logic           done,
  output logic [W/2-1:0] root,
  output logic [W/2:0]   rem
);

  localparam int RW = W / 2;
  localparam int CW = cnt_width(RW);

  if (!width_ok(W)) begin : g_width_check
    $error("sqrt_iter: W must be even and >= 4");
  end

  state_t        state_r;
  state_t        state_n_s;
  logic          accept_s;
  logic          calc_s;
  logic          last_s;
  logic          dp_en_s;
  logic [W-1:0]  x_r;
  logic [W-1:0]  x_d_s;
  logic [RW+1:0] r_r;
  logic [RW+1:0] r_d_s;
  logic [RW-1:0] q_r;
  logic [RW-1:0] q_d_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_d_s;
  logic [RW+1:0] step_r_s;
  logic [RW-1:0] step_q_s;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state logic; a start is accepted only in IDLE or in the DONE cycle.
  always_comb begin
    state_n_s = state_r;
    accept_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n_s = CALC;
          accept_s  = 1'b1;
        end else begin
          state_n_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_n_s = DONE;
        end else begin
          state_n_s = CALC;
        end
      end
      DONE: begin
        if (start) begin
          state_n_s = CALC;
          accept_s  = 1'b1;
        end else begin
          state_n_s = IDLE;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  assign calc_s  = (state_r == CALC);
  assign last_s  = calc_s && (cnt_r == {CW{1'b0}});
  assign dp_en_s = accept_s | calc_s;

  sqrt_step #(.RW(RW)) u_step (
    .r      (r_r),
    .q      (q_r),
    .pair   (x_r[W-1:W-2]),
    .r_next (step_r_s),
    .q_next (step_q_s)
  );

  // Datapath next values: initialise on accept, otherwise advance one iteration.
  always_comb begin
    if (accept_s) begin
      x_d_s   = din;
      r_d_s   = {(RW+2){1'b0}};
      q_d_s   = {RW{1'b0}};
      cnt_d_s = CW'(RW - 1);
    end else begin
      x_d_s   = {x_r[W-3:0], 2'b00};
      r_d_s   = step_r_s;
      q_d_s   = step_q_s;
      cnt_d_s = cnt_r - CW'(1'b1);
    end
  end

  sqrt_reg #(.N(W))    u_x_reg   (.clk(clk), .reset(reset), .en(dp_en_s), .d(x_d_s),   .q(x_r));
  sqrt_reg #(.N(RW+2)) u_r_reg   (.clk(clk), .reset(reset), .en(dp_en_s), .d(r_d_s),   .q(r_r));
  sqrt_reg #(.N(RW))   u_q_reg   (.clk(clk), .reset(reset), .en(dp_en_s), .d(q_d_s),   .q(q_r));
  sqrt_reg #(.N(CW))   u_cnt_reg (.clk(clk), .reset(reset), .en(dp_en_s), .d(cnt_d_s), .q(cnt_r));

  // Results load only on the final iteration and hold until the next one.
  sqrt_reg #(.N(RW))   u_root_reg (.clk(clk), .reset(reset), .en(last_s), .d(step_q_s),       .q(root));
  sqrt_reg #(.N(RW+1)) u_rem_reg  (.clk(clk), .reset(reset), .en(last_s), .d(step_r_s[RW:0]), .q(rem));

  // Status flags are registered copies of the upcoming state.
  sqrt_reg #(.N(1)) u_busy_reg (.clk(clk), .reset(reset), .en(1'b1), .d(state_n_s == CALC), .q(busy));
  sqrt_reg #(.N(1)) u_done_reg (.clk(clk), .reset(reset), .en(1'b1), .d(state_n_s == DONE), .q(done));

endmodule
